clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
Timekeeping and time-set controller for the 24-hour clock. It consumes the three single-cycle, debounced button pulses from the front-end button conditioner. It keeps hours, minutes and seconds from a local prescaler, and provides a set mode in which the operator edits hours and minutes. Its outputs feed the 7-segment display path, which blanks the field being edited in step with the blink phase.

Parameters:
HALF_DIV, 25000000, CLK cycles per half-second tick (50 MHz CLK); bench uses 4
Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-high
BIN  in  3  debounced one-cycle-high button pulses: [0]=MODE, [1]=SELECT, [2]=UP
HOUR  out  5  hours, binary 0..23
MIN  out  6  minutes, binary 0..59
SEC  out  6  seconds, binary 0..59
EDIT  out  2  one-hot edited field: [1]=hour, [0]=minute; 00 in RUN
BLINK  out  1  blink phase, toggles every half-second tick; display blanks field when EDIT bit & BLINK
SEC_TICK  out  1  one-cycle pulse, high on the cycle SEC is advanced in RUN

Behaviour:
- Reset (async, RST high): HOUR=0, MIN=0, SEC=0, EDIT=00, BLINK=0, SEC_TICK=0, state=RUN, prescaler=0, half-phase=0.
- All outputs are registered. A BIN pulse sampled at edge n is visible on the outputs after edge n.
- Prescaler:
  - Counts 0..HALF_DIV-1 and wraps.
  - The half tick fires on the cycle the count equals HALF_DIV-1.
  - Each half tick toggles BLINK and the half-phase bit.
  - A 1 Hz tick is a half tick with half-phase=1.
- Prescaler runs in all states. On every state change (any MODE pulse), the prescaler, half-phase and BLINK are cleared to 0.
- States: RUN, SET_HOUR, SET_MIN.
- RUN:
  - EDIT=00.
  - On each 1 Hz tick: SEC_TICK=1 for one cycle and SEC++.
  - SEC 59->0 carries MIN++; MIN 59->0 carries HOUR++; HOUR 23->0. 23:59:59 -> 00:00:00 on the same edge.
  - SELECT and UP are ignored.
  - MODE -> SET_HOUR: SEC cleared to 0 on the same edge.
- SET_HOUR:
  - EDIT=10; time does not advance; SEC_TICK=0.
  - UP: HOUR++, 23->0, no carry into other fields.
  - SELECT -> SET_MIN.
  - MODE -> RUN.
- SET_MIN:
  - EDIT=01; time does not advance.
  - UP: MIN++, 59->0, no carry into HOUR.
  - SELECT -> SET_HOUR.
  - MODE -> RUN.
- Simultaneous BIN bits in one cycle: MODE > SELECT > UP. Only the highest-priority action is taken; the others are dropped.
- A 1 Hz tick coinciding with MODE in RUN: the MODE action wins, SEC is cleared and no increment occurs.
- BIN held high for multiple cycles is treated as one event per high cycle. The upstream conditioner guarantees single-cycle pulses.
- Reset mid-operation (any state) returns immediately to the reset values above.
- Widths: counters are compared against terminal values with equality. Values outside the legal range cannot occur.

Test Plan:
- Reset with BIN=000 -> HOUR=0, MIN=0, SEC=0, EDIT=00, BLINK=0. Then with HALF_DIV=4: BLINK toggles every 4 cycles, SEC=1 and SEC_TICK pulses at cycle 8 after reset release.
- Rollover: preload time 23:59:59 via set mode plus run to seconds 59, then one 1 Hz tick -> 00:00:00 on one edge, SEC_TICK=1.
- Set flow:
  - Send MODE -> EDIT=10, SEC=0, time frozen for 100 cycles.
  - Send UP x25 -> HOUR wraps 0..23 and ends at 1.
  - Send SELECT -> EDIT=01; UP x61 -> MIN=1, HOUR stays 1.
  - Send MODE -> EDIT=00; SEC=1 exactly 8 cycles later.
- In RUN, send SELECT and UP pulses -> no change to HOUR/MIN/EDIT.
- Priority: BIN=111 in RUN -> SET_HOUR only, HOUR unchanged. BIN=110 in SET_HOUR -> SET_MIN, HOUR unchanged. MODE pulse coinciding with a 1 Hz tick -> SEC=0, no SEC_TICK.
- Assert RST while in SET_MIN with BLINK=1 -> all outputs return to reset values asynchronously, before the next CLK edge.

Source files
------------

// File: rtl/clock_set_ctrl_if.sv
// Button and time-display bundle of the 24-hour clock controller.
// The front end drives BIN; the controller drives the time/edit view.
interface clock_set_ctrl_if;
    logic [2:0] BIN;
    logic [4:0] HOUR;
    logic [5:0] MIN;
    logic [5:0] SEC;
    logic [1:0] EDIT;
    logic       BLINK;
    logic       SEC_TICK;

    modport master (
        output BIN,
        input  HOUR, MIN, SEC, EDIT, BLINK, SEC_TICK
    );

    modport slave (
        input  BIN,
        output HOUR, MIN, SEC, EDIT, BLINK, SEC_TICK
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// 24-hour timekeeper with hour/minute set mode and half-second blink.
// Button priority is MODE > SELECT > UP; only one action per cycle.
module clock_set_ctrl #(
    parameter int HALF_DIV = 25000000
) (
    input  logic             CLK,
    input  logic             RST,
    clock_set_ctrl_if.slave  bus
);

    localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

    typedef enum logic [1:0] {
        RUN,
        SET_HOUR,
        SET_MIN
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          phase;
    logic [4:0]    hour;
    logic [5:0]    min;
    logic [5:0]    sec;
    logic [1:0]    edit;
    logic          blink;
    logic          sec_tick;

    logic mode;
    logic sel;
    logic up;
    logic half;
    logic tick;

    assign mode = bus.BIN[0];
    assign sel  = bus.BIN[1];
    assign up   = bus.BIN[2];
    assign half = (cnt == LAST);
    assign tick = half & phase;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= RUN;
            cnt      <= '0;
            phase    <= 1'b0;
            hour     <= '0;
            min      <= '0;
            sec      <= '0;
            edit     <= 2'b00;
            blink    <= 1'b0;
            sec_tick <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            if (half) begin
                cnt   <= '0;
                blink <= ~blink;
                phase <= ~phase;
            end else begin
                cnt <= cnt + CW'(1);
            end
            // A mode change restarts the blink so the new field shows first
            if (mode) begin
                cnt   <= '0;
                blink <= 1'b0;
                phase <= 1'b0;
            end
            unique case (state)
                RUN: begin
                    if (mode) begin
                        state <= SET_HOUR;
                        edit  <= 2'b10;
                        sec   <= '0;
                    end else if (tick) begin
                        sec_tick <= 1'b1;
                        if (sec == 6'd59) begin
                            sec <= '0;
                            if (min == 6'd59) begin
                                min  <= '0;
                                hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
                            end else begin
                                min <= min + 6'd1;
                            end
                        end else begin
                            sec <= sec + 6'd1;
                        end
                    end
                end
                SET_HOUR: begin
                    if (mode) begin
                        state <= RUN;
                        edit  <= 2'b00;
                    end else if (sel) begin
                        state <= SET_MIN;
                        edit  <= 2'b01;
                    end else if (up) begin
                        hour <= (hour == 5'd23) ? 5'd0 : hour + 5'd1;
                    end
                end
                SET_MIN: begin
                    if (mode) begin
                        state <= RUN;
                        edit  <= 2'b00;
                    end else if (sel) begin
                        state <= SET_HOUR;
                        edit  <= 2'b10;
                    end else if (up) begin
                        min <= (min == 6'd59) ? 6'd0 : min + 6'd1;
                    end
                end
                default: begin
                    state <= RUN;
                    edit  <= 2'b00;
                end
            endcase
        end
    end

    assign bus.HOUR     = hour;
    assign bus.MIN      = min;
    assign bus.SEC      = sec;
    assign bus.EDIT     = edit;
    assign bus.BLINK    = blink;
    assign bus.SEC_TICK = sec_tick;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl with a 4-cycle half tick.
// Stimulus queues cycle-stamped expectations; a monitor compares them.
module tb_clock_set_ctrl;

    localparam int HD = 4;
    localparam logic [5:0] MH = 6'd1;
    localparam logic [5:0] MM = 6'd2;
    localparam logic [5:0] MS = 6'd4;
    localparam logic [5:0] ME = 6'd8;
    localparam logic [5:0] MB = 6'd16;
    localparam logic [5:0] MT = 6'd32;
    localparam logic [5:0] ALL = 6'd63;
    localparam logic [2:0] B_MODE = 3'b001;
    localparam logic [2:0] B_SEL  = 3'b010;
    localparam logic [2:0] B_UP   = 3'b100;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    clock_set_ctrl_if bus();

    clock_set_ctrl #(.HALF_DIV(HD)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        string      nm;
        logic [5:0] m;
        logic [4:0] h;
        logic [5:0] mi;
        logic [5:0] s;
        logic [1:0] e;
        logic       b;
        logic       t;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int dc, input logic [5:0] m,
                       input int h, input int mi, input int s,
                       input logic [1:0] e, input logic b, input logic t);
        exp_t x;
        x.cyc = cyc + dc;
        x.nm  = nm;
        x.m   = m;
        x.h   = 5'(h);
        x.mi  = 6'(mi);
        x.s   = 6'(s);
        x.e   = e;
        x.b   = b;
        x.t   = t;
        q.push_back(x);
    endtask

    task automatic pulse(input logic [2:0] b);
        bus.BIN = b;
        @(negedge CLK);
        bus.BIN = 3'b000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Monitor: also wakes on RST rising to observe the asynchronous clear
    initial begin
        exp_t x;
        logic bad;
        forever begin
            @(negedge CLK or posedge RST);
            #1;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                x = q.pop_front();
                checks++;
                bad = (x.m[0] && bus.HOUR !== x.h) ||
                      (x.m[1] && bus.MIN !== x.mi) ||
                      (x.m[2] && bus.SEC !== x.s) ||
                      (x.m[3] && bus.EDIT !== x.e) ||
                      (x.m[4] && bus.BLINK !== x.b) ||
                      (x.m[5] && bus.SEC_TICK !== x.t);
                if (x.cyc < cyc) begin
                    errors++;
                    $display("FAIL %s: not sampled, at cycle %0d required cycle %0d",
                             x.nm, cyc, x.cyc);
                end else if (bad) begin
                    errors++;
                    $display("FAIL %s: got h=%0d m=%0d s=%0d e=%b b=%b t=%b, required h=%0d m=%0d s=%0d e=%b b=%b t=%b (mask %b)",
                             x.nm, bus.HOUR, bus.MIN, bus.SEC, bus.EDIT,
                             bus.BLINK, bus.SEC_TICK, x.h, x.mi, x.s,
                             x.e, x.b, x.t, x.m);
                end
            end
        end
    end

    initial begin
        bit found;
        bus.BIN = 3'b000;
        RST = 1'b1;
        idle(3);
        RST = 1'b0;

        chk("reset", 0, ALL, 0, 0, 0, 2'b00, 0, 0);
        chk("blink_c3", 3, MS | MB, 0, 0, 0, 2'b00, 0, 0);
        chk("blink_c4", 4, MS | MB | MT, 0, 0, 0, 2'b00, 1, 0);
        chk("sec_c7", 7, MS | MB | MT, 0, 0, 0, 2'b00, 1, 0);
        chk("sec_c8", 8, ALL, 0, 0, 1, 2'b00, 0, 1);
        chk("tick_c9", 9, MS | MT, 0, 0, 1, 2'b00, 0, 0);
        idle(10);

        pulse(B_MODE);
        chk("enter_set", 0, ALL, 0, 0, 0, 2'b10, 0, 0);
        chk("frozen", 100, MH | MM | MS | ME | MT, 0, 0, 0, 2'b10, 0, 0);
        idle(100);

        for (int i = 1; i <= 25; i++) begin
            pulse(B_UP);
            if (i == 23) chk("hour_23", 0, MH | MM | ME, 23, 0, 0, 2'b10, 0, 0);
            if (i == 24) chk("hour_wrap", 0, MH | MM | ME, 0, 0, 0, 2'b10, 0, 0);
            if (i == 25) chk("hour_1", 0, MH | MM | ME, 1, 0, 0, 2'b10, 0, 0);
            idle(1);
        end

        pulse(B_SEL);
        chk("sel_min", 0, MH | MM | ME, 1, 0, 0, 2'b01, 0, 0);
        for (int i = 1; i <= 61; i++) begin
            pulse(B_UP);
            if (i == 59) chk("min_59", 0, MH | MM | ME, 1, 59, 0, 2'b01, 0, 0);
            if (i == 60) chk("min_wrap", 0, MH | MM | ME, 1, 0, 0, 2'b01, 0, 0);
            if (i == 61) chk("min_1", 0, MH | MM | MS | ME, 1, 1, 0, 2'b01, 0, 0);
        end

        pulse(B_MODE);
        chk("back_run", 0, ALL, 1, 1, 0, 2'b00, 0, 0);
        chk("run_c7", 7, MS | MT, 1, 1, 0, 2'b00, 0, 0);
        chk("run_c8", 8, MH | MM | MS | MT, 1, 1, 1, 2'b00, 0, 1);
        idle(9);

        pulse(B_SEL);
        chk("run_ign_sel", 0, MH | MM | ME, 1, 1, 0, 2'b00, 0, 0);
        pulse(B_UP);
        chk("run_ign_up", 0, MH | MM | ME, 1, 1, 0, 2'b00, 0, 0);
        pulse(3'b110);
        chk("run_ign_110", 0, MH | MM | ME, 1, 1, 0, 2'b00, 0, 0);

        pulse(3'b111);
        chk("prio_111", 0, MH | MM | MS | ME | MT, 1, 1, 0, 2'b10, 0, 0);
        pulse(3'b110);
        chk("prio_110", 0, MH | MM | ME, 1, 1, 0, 2'b01, 0, 0);

        for (int i = 0; i < 58; i++) pulse(B_UP);
        chk("pre_min59", 0, MH | MM | ME, 1, 59, 0, 2'b01, 0, 0);
        pulse(B_SEL);
        chk("sel_hour", 0, MH | MM | ME, 1, 59, 0, 2'b10, 0, 0);
        for (int i = 0; i < 22; i++) pulse(B_UP);
        chk("pre_hour23", 0, MH | MM | ME, 23, 59, 0, 2'b10, 0, 0);

        pulse(B_MODE);
        chk("run_2359", 0, ALL, 23, 59, 0, 2'b00, 0, 0);
        chk("run_c8b", 8, MH | MM | MS | MT, 23, 59, 1, 2'b00, 0, 1);
        chk("at_235959", 472, MH | MM | MS | ME | MT, 23, 59, 59, 2'b00, 0, 1);
        chk("hold_235959", 479, MH | MM | MS | MT, 23, 59, 59, 2'b00, 0, 0);
        chk("rollover", 480, MH | MM | MS | ME | MT, 0, 0, 0, 2'b00, 0, 1);
        idle(487);

        pulse(B_MODE);
        chk("mode_vs_tick", 0, ALL, 0, 0, 0, 2'b10, 0, 0);
        pulse(B_SEL);
        chk("sel_min2", 0, MH | MM | ME, 0, 0, 0, 2'b01, 0, 0);

        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (bus.BLINK === 1'b1) found = 1'b1;
            else @(negedge CLK);
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL blink_wait: BLINK stayed 0, required 1 within 20 cycles");
        end else begin
            #2;
            RST = 1'b1;
            chk("async_rst", 0, ALL, 0, 0, 0, 2'b00, 0, 0);
        end
        idle(2);
        RST = 1'b0;

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge CLK);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
